// File: rtl/exc_ctrl_pkg.sv
// Shared types and constants for the exception/interrupt controller.
package exc_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    HANDLER = 1'b1
  } state_t;

  localparam logic [1:0] VEC_NONE  = 2'd0;
  localparam logic [1:0] VEC_IRQ   = 2'd1;
  localparam logic [1:0] VEC_UNDEF = 2'd2;

  // The cause register is {irq_flag, index}; the flag sits just above the index bits.
  function automatic int cause_msb(input int idx_w);
    return idx_w;
  endfunction

endpackage

// File: rtl/exc_ctrl_irq_prio_enc.sv
// Lowest-index-first priority encoder: index 0 always wins.
module irq_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot
);

  // Scan from the top down so the last match written is the lowest set index.
  always_comb begin
    valid  = |req;
    idx    = '0;
    onehot = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx       = IDX_W'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller for the MIPS cores: qualifies irq and undef sources
// against user mode and handler state. Define EXC_IRQ_EDGE_EN for edge-latched pending bits.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int                 NUM_IRQ  = 4,
  parameter int                 IDX_W    = $clog2(NUM_IRQ),
  parameter int                 CNT_W    = 16,
  parameter logic [NUM_IRQ-1:0] MASK_RST = {NUM_IRQ{1'b1}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               instr_valid_i,
  input  logic               kernel_i,
  input  logic               undef_i,
  input  logic               eret_i,
  input  logic               mask_wr_i,
  input  logic [NUM_IRQ-1:0] mask_wdata_i,
  output logic               take_o,
  output logic [1:0]         vec_sel_o,
  output logic [NUM_IRQ-1:0] ack_o,
  output logic [IDX_W:0]     cause_o,
  output logic [NUM_IRQ-1:0] pending_o,
  output logic [NUM_IRQ-1:0] mask_o,
  output logic               busy_o,
  output logic [CNT_W-1:0]   exc_count_o
);

  state_t             state;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] mask;
  logic [IDX_W:0]     cause;
  logic [CNT_W-1:0]   count;

  logic               elig;
  logic               irq_hit;
  logic               undef_hit;
  logic               enc_valid;
  logic [IDX_W-1:0]   enc_idx;
  logic [NUM_IRQ-1:0] enc_onehot;

  irq_prio_enc #(
    .N     (NUM_IRQ),
    .IDX_W (IDX_W)
  ) u_prio (
    .req    (pending & mask),
    .valid  (enc_valid),
    .idx    (enc_idx),
    .onehot (enc_onehot)
  );

  // Reset gates eligibility so no take escapes during the reset cycle.
  assign elig      = !reset && instr_valid_i && !kernel_i && (state == IDLE);
  assign irq_hit   = elig && enc_valid;
  assign undef_hit = elig && undef_i && !irq_hit;
  assign take_o    = irq_hit || undef_hit;
  assign ack_o     = irq_hit ? enc_onehot : '0;
  assign vec_sel_o = irq_hit ? VEC_IRQ : (undef_hit ? VEC_UNDEF : VEC_NONE);

`ifdef EXC_IRQ_EDGE_EN
  logic [NUM_IRQ-1:0] irq_q;

  // New rising edges are OR-ed in after the clear, so a same-cycle set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q   <= '0;
      pending <= '0;
    end else begin
      irq_q   <= irq_in;
      pending <= (pending & ~ack_o) | (irq_in & ~irq_q);
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= irq_in;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      mask  <= MASK_RST;
      cause <= '0;
      count <= '0;
    end else begin
      if (mask_wr_i) begin
        mask <= mask_wdata_i;
      end
      case (state)
        IDLE:    if (take_o) state <= HANDLER;
        HANDLER: if (eret_i && instr_valid_i) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (take_o) begin
        cause[cause_msb(IDX_W)] <= irq_hit;
        cause[IDX_W-1:0]        <= irq_hit ? enc_idx : '0;
        if (count != {CNT_W{1'b1}}) begin
          count <= count + CNT_W'(1);
        end
      end
    end
  end

  assign busy_o      = (state == HANDLER);
  assign cause_o     = cause;
  assign pending_o   = pending;
  assign mask_o      = mask;
  assign exc_count_o = count;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl against a behavioural model of pending/mask/cause/count.
module tb_exc_ctrl;

  localparam int NI = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NI-1:0] irq;
  logic          iv, kern, und, eret, mwr;
  logic [NI-1:0] mdata;

  logic          take_o;
  logic [1:0]    vec_sel_o;
  logic [NI-1:0] ack_o;
  logic [2:0]    cause_o;
  logic [NI-1:0] pending_o;
  logic [NI-1:0] mask_o;
  logic          busy_o;
  logic [CW-1:0] exc_count_o;

  int tests = 0;
  int fails = 0;

  // Model state
  logic [NI-1:0] m_pending;
  logic [NI-1:0] m_mask;
  logic [2:0]    m_cause;
  logic [CW-1:0] m_count;
  logic          m_busy;
`ifdef EXC_IRQ_EDGE_EN
  logic [NI-1:0] m_irq_q;
`endif

  logic [22:0] obs_all;

  exc_ctrl #(
    .NUM_IRQ (NI),
    .CNT_W   (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .irq_in        (irq),
    .instr_valid_i (iv),
    .kernel_i      (kern),
    .undef_i       (und),
    .eret_i        (eret),
    .mask_wr_i     (mwr),
    .mask_wdata_i  (mdata),
    .take_o        (take_o),
    .vec_sel_o     (vec_sel_o),
    .ack_o         (ack_o),
    .cause_o       (cause_o),
    .pending_o     (pending_o),
    .mask_o        (mask_o),
    .busy_o        (busy_o),
    .exc_count_o   (exc_count_o)
  );

  always #5 clk = ~clk;

  assign obs_all = {take_o, vec_sel_o, ack_o, cause_o, pending_o, mask_o, busy_o, exc_count_o};

  function automatic logic [13:0] S(input logic r, input logic v, input logic k, input logic u,
                                     input logic e, input logic [3:0] q, input logic w,
                                     input logic [3:0] d);
    return {r, v, k, u, e, q, w, d};
  endfunction

  function automatic logic [22:0] exp_all();
    logic [3:0] eff, ack;
    logic       el, ih, uh;
    logic [1:0] v;
    eff = m_pending & m_mask;
    el  = !reset && iv && !kern && !m_busy;
    ih  = el && (eff != 4'b0);
    uh  = el && und && !ih;
    ack = ih ? (eff & (~eff + 4'd1)) : 4'b0;
    v   = ih ? 2'd1 : (uh ? 2'd2 : 2'd0);
    return {ih | uh, v, ack, m_cause, m_pending, m_mask, m_busy, m_count};
  endfunction

  task automatic model_update();
    logic [3:0] eff, ack;
    logic       el, ih, uh;
    logic [1:0] idx;
    eff = m_pending & m_mask;
    el  = !reset && iv && !kern && !m_busy;
    ih  = el && (eff != 4'b0);
    uh  = el && und && !ih;
    ack = ih ? (eff & (~eff + 4'd1)) : 4'b0;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) if (ack[i]) idx = 2'(i);
    if (reset) begin
      m_pending = '0;
      m_mask    = 4'hF;
      m_cause   = '0;
      m_count   = '0;
      m_busy    = 1'b0;
`ifdef EXC_IRQ_EDGE_EN
      m_irq_q   = '0;
`endif
    end else begin
`ifdef EXC_IRQ_EDGE_EN
      m_pending = (m_pending & ~ack) | (irq & ~m_irq_q);
      m_irq_q   = irq;
`else
      m_pending = irq;
`endif
      if (mwr) m_mask = mdata;
      if (ih || uh) begin
        m_cause = ih ? {1'b1, idx} : 3'b000;
        if (m_count != 4'hF) m_count = m_count + 4'd1;
        m_busy = 1'b1;
      end else if (m_busy && eret && iv) begin
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic apply(input logic [13:0] s);
    {reset, iv, kern, und, eret, irq, mwr, mdata} = s;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [13:0] st[$];
    apply(S(1, 0, 0, 0, 0, 4'h0, 0, 4'h0));
    tick();
    st = '{S(1, 1, 0, 1, 0, 4'hF, 0, 4'h0), S(1, 1, 0, 0, 0, 4'hF, 1, 4'h0),
           S(0, 0, 0, 0, 0, 4'h0, 0, 4'h0)};
    foreach (st[i]) begin
      apply(st[i]);
      tests++;
      if (obs_all !== exp_all()) begin
        fails++;
        $display("[TB] FAIL reset step %0d: got %h expected %h", i, obs_all, exp_all());
      end
      if (i == 0) begin
        tests++;
        if ({take_o, vec_sel_o, ack_o, mask_o} !== {1'b0, 2'd0, 4'h0, 4'hF}) begin
          fails++;
          $display("[TB] FAIL reset_values: got take=%b vec=%0d ack=%b mask=%b required 0 0 0000 1111",
                   take_o, vec_sel_o, ack_o, mask_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_irq_basic();
    logic [13:0] st[$];
    st = '{S(0, 0, 0, 0, 0, 4'b0100, 0, 4'h0), S(0, 1, 0, 0, 0, 4'b0000, 0, 4'h0),
           S(0, 0, 0, 0, 0, 4'b0000, 0, 4'h0), S(0, 1, 1, 0, 1, 4'b0000, 0, 4'h0),
           S(0, 0, 0, 0, 0, 4'b0000, 0, 4'h0)};
    foreach (st[i]) begin
      apply(st[i]);
      tests++;
      if (obs_all !== exp_all()) begin
        fails++;
        $display("[TB] FAIL irq_basic step %0d: got %h expected %h", i, obs_all, exp_all());
      end
      if (i == 1) begin
        tests++;
        if ({take_o, vec_sel_o, ack_o} !== {1'b1, 2'd1, 4'b0100}) begin
          fails++;
          $display("[TB] FAIL irq_take: got take=%b vec=%0d ack=%b required 1 1 0100",
                   take_o, vec_sel_o, ack_o);
        end
      end
      if (i == 2) begin
        tests++;
        if ({cause_o, busy_o, exc_count_o} !== {3'b110, 1'b1, 4'd1}) begin
          fails++;
          $display("[TB] FAIL irq_cause: got cause=%b busy=%b count=%0d required 110 1 1",
                   cause_o, busy_o, exc_count_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_priority();
    logic [13:0] st[$];
    st = '{S(0, 0, 0, 0, 0, 4'b1010, 0, 4'h0), S(0, 1, 0, 0, 0, 4'b1010, 0, 4'h0),
           S(0, 0, 0, 0, 0, 4'b1000, 0, 4'h0), S(0, 1, 1, 0, 1, 4'b1000, 0, 4'h0),
           S(0, 1, 0, 0, 0, 4'b1000, 0, 4'h0), S(0, 0, 0, 0, 0, 4'b0000, 0, 4'h0),
           S(0, 1, 1, 0, 1, 4'b0000, 0, 4'h0), S(0, 0, 0, 0, 0, 4'b0000, 0, 4'h0)};
    foreach (st[i]) begin
      apply(st[i]);
      tests++;
      if (obs_all !== exp_all()) begin
        fails++;
        $display("[TB] FAIL priority step %0d: got %h expected %h", i, obs_all, exp_all());
      end
      if (i == 1 || i == 4) begin
        tests++;
        if (ack_o !== ((i == 1) ? 4'b0010 : 4'b1000)) begin
          fails++;
          $display("[TB] FAIL priority_ack step %0d: got %b required %b", i, ack_o,
                   (i == 1) ? 4'b0010 : 4'b1000);
        end
      end
      if (i == 3) begin
        tests++;
        if (take_o !== 1'b0) begin
          fails++;
          $display("[TB] FAIL eret_no_take: got take=%b required 0", take_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_undef();
    logic [13:0] st[$];
    st = '{S(0, 0, 0, 0, 0, 4'b0001, 0, 4'h0), S(0, 1, 0, 1, 0, 4'b0000, 0, 4'h0),
           S(0, 0, 0, 0, 0, 4'b0000, 0, 4'h0), S(0, 1, 1, 0, 1, 4'b0000, 0, 4'h0),
           S(0, 1, 0, 1, 0, 4'b0000, 0, 4'h0), S(0, 0, 0, 0, 0, 4'b0000, 0, 4'h0),
           S(0, 1, 1, 0, 1, 4'b0000, 0, 4'h0), S(0, 1, 1, 1, 0, 4'b0000, 0, 4'h0),
           S(0, 0, 0, 0, 0, 4'b0000, 0, 4'h0)};
    foreach (st[i]) begin
      apply(st[i]);
      tests++;
      if (obs_all !== exp_all()) begin
        fails++;
        $display("[TB] FAIL undef step %0d: got %h expected %h", i, obs_all, exp_all());
      end
      if (i == 1 || i == 4) begin
        tests++;
        if (vec_sel_o !== ((i == 1) ? 2'd1 : 2'd2)) begin
          fails++;
          $display("[TB] FAIL undef_vec step %0d: got %0d required %0d", i, vec_sel_o,
                   (i == 1) ? 1 : 2);
        end
      end
      if (i == 5) begin
        tests++;
        if (cause_o !== 3'b000) begin
          fails++;
          $display("[TB] FAIL undef_cause: got %b required 000", cause_o);
        end
      end
      if (i == 7) begin
        tests++;
        if (take_o !== 1'b0) begin
          fails++;
          $display("[TB] FAIL undef_kernel: got take=%b required 0", take_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_mask();
    logic [13:0] st[$];
    st = '{S(0, 0, 0, 0, 0, 4'b0001, 0, 4'h0), S(0, 1, 0, 0, 0, 4'b0000, 1, 4'b1110),
           S(0, 0, 0, 0, 0, 4'b0000, 0, 4'h0), S(0, 1, 1, 0, 1, 4'b0000, 0, 4'h0),
           S(0, 0, 0, 0, 0, 4'b0001, 0, 4'h0), S(0, 1, 0, 0, 0, 4'b0001, 0, 4'h0),
           S(0, 1, 0, 0, 0, 4'b0001, 1, 4'b1111), S(0, 1, 0, 0, 0, 4'b0001, 0, 4'h0),
           S(0, 0, 0, 0, 0, 4'b0000, 0, 4'h0), S(0, 1, 1, 0, 1, 4'b0000, 0, 4'h0),
           S(0, 0, 0, 0, 0, 4'b0000, 0, 4'h0)};
    foreach (st[i]) begin
      apply(st[i]);
      tests++;
      if (obs_all !== exp_all()) begin
        fails++;
        $display("[TB] FAIL mask step %0d: got %h expected %h", i, obs_all, exp_all());
      end
      if (i == 1 || i == 5 || i == 6 || i == 7) begin
        tests++;
        if (take_o !== (i == 1 || i == 7)) begin
          fails++;
          $display("[TB] FAIL mask_take step %0d: got %b required %b", i, take_o,
                   (i == 1 || i == 7));
        end
      end
      if (i == 2) begin
        tests++;
        if (mask_o !== 4'b1110) begin
          fails++;
          $display("[TB] FAIL mask_value: got %b required 1110", mask_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_in_handler();
    logic [13:0] st[$];
    st = '{S(0, 0, 0, 0, 0, 4'b0011, 0, 4'h0), S(0, 1, 0, 0, 0, 4'b0011, 0, 4'h0),
           S(1, 1, 0, 0, 0, 4'b0011, 0, 4'h0), S(0, 0, 0, 0, 0, 4'b0000, 0, 4'h0),
           S(0, 0, 0, 0, 0, 4'b0000, 0, 4'h0)};
    foreach (st[i]) begin
      apply(st[i]);
      tests++;
      if (obs_all !== exp_all()) begin
        fails++;
        $display("[TB] FAIL reset_handler step %0d: got %h expected %h", i, obs_all, exp_all());
      end
      if (i == 3) begin
        tests++;
        if ({busy_o, pending_o, exc_count_o} !== {1'b0, 4'b0000, 4'd0}) begin
          fails++;
          $display("[TB] FAIL reset_handler_state: got busy=%b pending=%b count=%0d required 0 0000 0",
                   busy_o, pending_o, exc_count_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_level_hold();
    logic [13:0] st[$];
    st = '{S(0, 0, 0, 0, 0, 4'b0100, 0, 4'h0), S(0, 1, 0, 0, 0, 4'b0100, 0, 4'h0),
           S(0, 1, 1, 0, 1, 4'b0100, 0, 4'h0), S(0, 1, 0, 0, 0, 4'b0100, 0, 4'h0),
           S(0, 0, 0, 0, 0, 4'b0000, 0, 4'h0), S(0, 1, 1, 0, 1, 4'b0000, 0, 4'h0),
           S(0, 0, 0, 0, 0, 4'b0000, 0, 4'h0)};
    foreach (st[i]) begin
      apply(st[i]);
      tests++;
      if (obs_all !== exp_all()) begin
        fails++;
        $display("[TB] FAIL level_hold step %0d: got %h expected %h", i, obs_all, exp_all());
      end
`ifdef EXC_IRQ_EDGE_EN
      if (i == 3) begin
        tests++;
        if (take_o !== 1'b0) begin
          fails++;
          $display("[TB] FAIL edge_single_take: got take=%b required 0", take_o);
        end
      end
`endif
      tick();
    end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 20; n++) begin
      apply(S(0, 1, 0, 1, 0, 4'h0, 0, 4'h0));
      tests++;
      if (obs_all !== exp_all()) begin
        fails++;
        $display("[TB] FAIL saturation take %0d: got %h expected %h", n, obs_all, exp_all());
      end
      tick();
      apply(S(0, 1, 1, 0, 1, 4'h0, 0, 4'h0));
      tick();
    end
    apply(S(0, 0, 0, 0, 0, 4'h0, 0, 4'h0));
    tests++;
    if (exc_count_o !== 4'hF) begin
      fails++;
      $display("[TB] FAIL saturation_count: got %0d required 15", exc_count_o);
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      apply(S(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1,
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0, 4'($urandom & $urandom),
              $urandom_range(0, 7) == 0, 4'($urandom)));
      tests++;
      if (obs_all !== exp_all()) begin
        fails++;
        $display("[TB] FAIL random cycle %0d: got %h expected %h", n, obs_all, exp_all());
      end
      tick();
    end
  endtask

  initial begin
    {reset, iv, kern, und, eret, irq, mwr, mdata} = {1'b1, 13'b0};
    m_pending = '0;
    m_mask    = 4'hF;
    m_cause   = '0;
    m_count   = '0;
    m_busy    = 1'b0;
`ifdef EXC_IRQ_EDGE_EN
    m_irq_q   = '0;
`endif
    @(negedge clk);
    test_reset();
    test_irq_basic();
    test_priority();
    test_undef();
    test_mask();
    test_reset_in_handler();
    test_level_hold();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Parametrised exception/interrupt controller for the MIPS single-cycle and pipelined cores. It accepts NUM_IRQ interrupt lines plus the decoder's undefined-instruction flag, and qualifies them against kernel mode (PC[31]). It tracks in-handler state, prioritises and masks sources, and produces the take pulse and vector select that drive PCSrc 4/5, RegDst 3 and MemToReg 2. It sits beside the control decoder and holds registered pending, mask, cause and count state.

## Interface
- NUM_IRQ, 4 — interrupt lines; index 0 is highest priority
- IDX_W, $clog2(NUM_IRQ) — irq index width
- CNT_W, 16 — width of exception counter
- MASK_RST, all ones — mask register reset value
- clk  in  1  — clock
- reset  in  1  — synchronous, active-high reset
- irq_in  in  NUM_IRQ  — interrupt request lines
- instr_valid_i  in  1  — an instruction commits this cycle
- kernel_i  in  1  — PC[31] of the committing instruction
- undef_i  in  1  — decoder flags the committing opcode undefined
- eret_i  in  1  — committing instruction is the handler return (jr $k0)
- mask_wr_i  in  1  — write mask register
- mask_wdata_i  in  NUM_IRQ  — new mask, 1 = enabled
- take_o  out  1  — exception taken this cycle
- vec_sel_o  out  2  — 0 none, 1 irq vector, 2 undef vector
- ack_o  out  NUM_IRQ  — one-hot acknowledge of the taken irq
- cause_o  out  IDX_W+1  — MSB 1 = irq, 0 = undef; low bits = irq index
- pending_o  out  NUM_IRQ  — pending register
- mask_o  out  NUM_IRQ  — mask register
- busy_o  out  1  — state is HANDLER
- exc_count_o  out  CNT_W  — exceptions taken, saturating

## Operation
- FSM with two states, IDLE and HANDLER.
  - IDLE → HANDLER on take_o.
  - HANDLER → IDLE on eret_i && instr_valid_i.
  - No other transitions.
- Eligibility: elig = instr_valid_i && !kernel_i && state==IDLE.
- irq_hit = elig && |(pending & mask).
- undef_hit = elig && undef_i && !irq_hit. Irq wins over undef in the same cycle.
- take_o = irq_hit || undef_hit.
- vec_sel_o = 1 on irq_hit, 2 on undef_hit, else 0.
- ack_o is one-hot at the lowest set index of pending&mask when irq_hit, else 0.
- On take, at the next edge:
  - cause_o loads {1,index} for an irq or {0,0} for undef, and holds until the next take.
  - The taken pending bit clears.
  - exc_count_o increments and saturates at all ones.
- Mask write takes effect at the next edge. A take in the same cycle uses the old mask.
- Undef or irq while busy_o, or while kernel_i=1, is ignored. Irq pending bits stay set; undef is dropped.
- eret_i outside HANDLER is ignored.

## Timing
- take_o, vec_sel_o and ack_o are combinational, with zero latency from instr_valid_i. This matches the decoder's same-cycle PCSrc selection.
- busy_o, cause_o, pending_o, mask_o and exc_count_o are registered and update one edge after the causing event.
- Pending capture: a pending bit is visible one edge after the irq event. The earliest take is that cycle.
- Simultaneous set and clear of the same pending bit: set wins.
- The eret cycle itself cannot take, because kernel_i=1. A queued irq is taken on the first user-mode commit after return.
- Reset values: state IDLE, pending 0, mask MASK_RST, cause 0, count 0. All combinational outputs are 0 in the reset cycle.
- Reset asserted in HANDLER returns to IDLE with no eret.

## Configuration
- EXC_IRQ_EDGE_EN defined: each pending bit sets on a rising edge of irq_in, detected against a registered copy of irq_in, and clears on take. A level held high causes exactly one exception.
- EXC_IRQ_EDGE_EN undefined: pending = irq_in registered, with no latch and no clear on take. The source must drop the request on ack_o, otherwise it re-fires after every eret.

## Structure
- Package exc_pkg holds:
  - state enum (IDLE, HANDLER)
  - VEC_NONE, VEC_IRQ and VEC_UNDEF localparams
  - cause MSB position helper
- Sub-module irq_prio_enc: parametrised lowest-index-first encoder. Outputs valid, index and one-hot; used for ack_o and cause.

## Test plan
- Reset, NUM_IRQ=4, then pulse irq_in=4'b0100 and commit user instruction → take_o=1, vec_sel_o=1, ack_o=4'b0100, next edge cause_o=3'b110, busy_o=1, exc_count_o=1.
- Pending 4'b1010, mask 4'b1111 → ack_o=4'b0010; after eret and next user commit → ack_o=4'b1000.
- undef_i=1 with pending 4'b0001 in the same user commit → vec_sel_o=1 (irq wins); undef is dropped.
- undef_i=1, no irq, kernel_i=0 → vec_sel_o=2, cause_o=3'b000 next edge; repeat with kernel_i=1 → take_o=0.
- Mask write 4'b1110 in the same cycle as irq_hit on bit 0 → take still occurs. Later bit 0 pending → no take until the mask is restored.
- Reset pulsed in HANDLER with pending 4'b0011 → busy_o=0, pending_o=0, exc_count_o=0 next edge. With EXC_IRQ_EDGE_EN, irq held high after eret → no second take.
